// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Magnitude helpers work on a 64-bit carrier; callers slice back to operand width.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  typedef struct packed {
    logic load;
    logic step;
  } dp_ctrl_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic logic [63:0] twos_neg(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  // The most negative value maps onto 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [63:0] mag(input logic [63:0] v, input int w, input logic sgn);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (sgn && v[w-1]) return twos_neg(v) & mask;
    return v;
  endfunction

endpackage

// File: rtl/seq_mult_param_if.sv
// Request/result bundle between the issuing controller and the multiplier.
interface seq_mult_param_if #(parameter int DP_WIDTH = 4);
  logic                    start;
  logic                    signed_mode;
  logic [DP_WIDTH-1:0]     multiplicand;
  logic [DP_WIDTH-1:0]     multiplier;
  logic [2*DP_WIDTH-1:0]   product;
  logic                    ready;
  logic                    done;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  product, ready, done
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output product, ready, done
  );
endinterface

// File: rtl/seq_mult_datapath.sv
// Shift-add core: B/C/A/Q registers, P bit counter and sign fix-up of {A,Q}.
// SEQ_MULT_ZERO_SKIP_EN forces Q to zero on a zero-magnitude load.
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int DP_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_b,
  input  dp_ctrl_t              ctrl,
  input  logic                  signed_mode,
  input  logic [DP_WIDTH-1:0]   multiplicand,
  input  logic [DP_WIDTH-1:0]   multiplier,
  output logic                  zero_op,
  output logic                  last,
  output logic [2*DP_WIDTH-1:0] result
);

  localparam int W  = DP_WIDTH;
  localparam int CW = cnt_width(DP_WIDTH);
  localparam int XW = 64 - DP_WIDTH;

  logic [W-1:0]    b, a, q;
  logic            c, neg;
  logic [CW-1:0]   p;
  logic [63:0]     b_ext, q_ext;
  logic [W-1:0]    b_mag, q_mag;
  logic [W:0]      sum;
  logic [2*W-1:0]  aq;
  logic            unused_bits;

  assign b_ext   = mag({{XW{1'b0}}, multiplicand}, W, signed_mode);
  assign q_ext   = mag({{XW{1'b0}}, multiplier}, W, signed_mode);
  assign b_mag   = b_ext[W-1:0];
  assign q_mag   = q_ext[W-1:0];
  assign zero_op = (b_mag == '0) || (q_mag == '0);

  assign sum  = {1'b0, a} + {1'b0, (q[0] ? b : {W{1'b0}})};
  assign last = (p == CW'(1));
  assign aq   = {a, q};
  // Negating zero wraps back to zero, so no negative-zero case exists.
  assign result = neg ? (~aq + {{(2*W-1){1'b0}}, 1'b1}) : aq;

  assign unused_bits = ^{b_ext[63:W], q_ext[63:W], c};

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      b   <= '0;
      c   <= 1'b0;
      a   <= '0;
      q   <= '0;
      p   <= '0;
      neg <= 1'b0;
    end else if (ctrl.load) begin
      b   <= b_mag;
      c   <= 1'b0;
      a   <= '0;
      p   <= CW'(W);
      neg <= signed_mode & (multiplicand[W-1] ^ multiplier[W-1]);
`ifdef SEQ_MULT_ZERO_SKIP_EN
      q   <= zero_op ? '0 : q_mag;
`else
      q   <= q_mag;
`endif
    end else if (ctrl.step) begin
      // Add and right shift folded into one update: the carry lands in A's MSB.
      {c, a, q} <= {1'b0, sum, q[W-1:1]};
      p         <= p - CW'(1);
    end
  end

endmodule

// File: rtl/seq_mult_param.sv
// Sequential signed/unsigned multiplier, one multiplier bit per clock.
// Optional SEQ_MULT_ZERO_SKIP_EN: zero-magnitude operands go straight to FINISH.
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int DP_WIDTH = 4
) (
  input  logic           clock,
  input  logic           reset_b,
  seq_mult_param_if.slave bus
);

  if (DP_WIDTH < 2 || DP_WIDTH > 32) begin : g_bad_width
    $error("seq_mult_param: DP_WIDTH out of range 2..32");
  end

  state_t                 state, state_nxt;
  dp_ctrl_t               ctrl;
  logic                   zero_op, last, skip;
  logic [2*DP_WIDTH-1:0]  result, product;
  logic                   done;

  seq_mult_datapath #(.DP_WIDTH(DP_WIDTH)) u_dp (
    .clock       (clock),
    .reset_b     (reset_b),
    .ctrl        (ctrl),
    .signed_mode (bus.signed_mode),
    .multiplicand(bus.multiplicand),
    .multiplier  (bus.multiplier),
    .zero_op     (zero_op),
    .last        (last),
    .result      (result)
  );

`ifdef SEQ_MULT_ZERO_SKIP_EN
  assign skip = zero_op;
`else
  logic unused_zero;
  assign skip        = 1'b0;
  assign unused_zero = zero_op;
`endif

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          ctrl.load = 1'b1;
          state_nxt = skip ? FINISH : CALC;
        end
      end
      CALC: begin
        ctrl.step = 1'b1;
        if (last) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Product only moves on the FINISH edge; done marks the cycle after it.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == FINISH);
      if (state == FINISH) product <= result;
    end
  end

  assign bus.product = product;
  assign bus.ready   = (state == IDLE);
  assign bus.done    = done;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param at DP_WIDTH=4; honours SEQ_MULT_ZERO_SKIP_EN.
module tb_seq_mult_param;

  logic clk = 1'b0;
  logic rst_b;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  seq_mult_param_if #(.DP_WIDTH(4)) bus ();

  seq_mult_param #(.DP_WIDTH(4)) dut (
    .clock  (clk),
    .reset_b(rst_b),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, track latency, ready-low cycles and product hold until done.
  task automatic mul_op(input string tag, input logic sm, input logic [3:0] b, input logic [3:0] q,
                        input logic [7:0] exp, input int exp_lat, input bit scramble);
    logic [7:0] prev;
    int lat, rlow;
    bit got, hold_ok;
    @(negedge clk);
    prev = bus.product;
    bus.start = 1'b1; bus.signed_mode = sm; bus.multiplicand = b; bus.multiplier = q;
    @(posedge clk);
    lat = 0; rlow = 0; got = 0; hold_ok = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.done) got = 1;
      else begin
        if (!bus.ready) rlow++;
        if (bus.product !== prev) hold_ok = 0;
        bus.start = 1'b0;
        if (scramble) begin
          bus.multiplicand = 4'($urandom);
          bus.multiplier   = 4'($urandom);
          bus.signed_mode  = 1'($urandom);
        end
        @(posedge clk);
        lat++;
      end
    end
    chk({tag, ".done_seen"}, 32'(got), 32'd1);
    chk({tag, ".prod"}, 32'(bus.product), 32'(exp));
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".ready_low"}, 32'(rlow), 32'(exp_lat));
    chk({tag, ".ready_at_done"}, 32'(bus.ready), 32'd1);
    if (scramble) chk({tag, ".hold"}, 32'(hold_ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, dcnt, zlat;
    rst_b = 1'b0;
    bus.start = 1'b0; bus.signed_mode = 1'b0;
    bus.multiplicand = '0; bus.multiplier = '0;
    repeat (2) @(negedge clk);
    chk("rst.product", 32'(bus.product), 32'h0);
    chk("rst.ready", 32'(bus.ready), 32'd1);
    chk("rst.done", 32'(bus.done), 32'd0);
    rst_b = 1'b1;

    mul_op("u8x9",   1'b0, 4'b1000, 4'b1001, 8'h48, 5, 0);
    mul_op("u15x15", 1'b0, 4'b1111, 4'b1111, 8'hE1, 5, 0);
    mul_op("s-8x-7", 1'b1, 4'b1000, 4'b1001, 8'h38, 5, 0);
    mul_op("s-8x-8", 1'b1, 4'b1000, 4'b1000, 8'h40, 5, 0);
    mul_op("s7x-1",  1'b1, 4'b0111, 4'b1111, 8'hF9, 5, 0);
    mul_op("s-8x7",  1'b1, 4'b1000, 4'b0111, 8'hC8, 5, 0);

    // start held high: first op accepted, second taken at the edge ending the done cycle
    @(negedge clk);
    bus.start = 1'b1; bus.signed_mode = 1'b0; bus.multiplicand = 4'b0011; bus.multiplier = 4'b0011;
    @(posedge clk);
    dcnt = 0; first = 0; second = 0;
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        dcnt++;
        if (dcnt == 1) first = e; else second = e;
        chk($sformatf("busy.prod%0d", dcnt), 32'(bus.product), 32'h09);
      end
    end
    bus.start = 1'b0;
    chk("busy.done_count", 32'(dcnt), 32'd2);
    chk("busy.first_lat", 32'(first), 32'd5);
    chk("busy.spacing", 32'(second - first), 32'd6);
    @(negedge clk);
    chk("busy.idle_after", 32'(bus.ready), 32'd1);

    // reset pulse at the 3rd CALC edge kills the op and clears product
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 4'b0110; bus.multiplier = 4'b0101;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    #1;
    chk("abort.product", 32'(bus.product), 32'h0);
    chk("abort.ready", 32'(bus.ready), 32'd1);
    chk("abort.done", 32'(bus.done), 32'd0);
    @(negedge clk); rst_b = 1'b1;
    dcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("abort.no_done", 32'(dcnt), 32'd0);
    mul_op("u5x3", 1'b0, 4'b0101, 4'b0011, 8'h0F, 5, 0);

    mul_op("scramble", 1'b1, 4'b0110, 4'b1101, 8'hEE, 5, 1);

`ifdef SEQ_MULT_ZERO_SKIP_EN
    zlat = 1;
`else
    zlat = 5;
`endif
    mul_op("zero_s", 1'b1, 4'b0000, 4'b1011, 8'h00, zlat, 0);
    mul_op("s-8x-7b", 1'b1, 4'b1000, 4'b1001, 8'h38, 5, 0);
    mul_op("zero_u", 1'b0, 4'b1011, 4'b0000, 8'h00, zlat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
